// File: rtl/dvp_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_pattern_tx_if
//  Description : Bundle of control inputs and parallel camera outputs for
//                the DVP test-pattern transmitter.
//                  enable      - level, frames produced while high
//                  pattern_sel - 0 bars, 1 grey ramp, 2 checker, 3 frame count
//                  data_out    - pixel byte, valid while h_ref=1
//                  h_ref       - active-byte qualifier
//                  v_sync      - frame sync, active high
//                  busy        - high from VSYNC entry until frame end
//                  frame_done  - one-clock pulse on the last clock of a frame
//                master modport: the transmitter; slave modport: its user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dvp_pattern_tx_if;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [7:0] data_out;
    logic       h_ref;
    logic       v_sync;
    logic       busy;
    logic       frame_done;

    modport master (
        input  enable,
        input  pattern_sel,
        output data_out,
        output h_ref,
        output v_sync,
        output busy,
        output frame_done
    );

    modport slave (
        output enable,
        output pattern_sel,
        input  data_out,
        input  h_ref,
        input  v_sync,
        input  busy,
        input  frame_done
    );
endinterface
`default_nettype wire

// File: rtl/dvp_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_pattern_tx
//  Description : OV7670-style parallel camera transmitter producing frames of
//                synthetic RGB565 test patterns, one byte per clock, high
//                byte first. Stands in for the sensor during bring-up and
//                loopback tests of the capture / frame-buffer path.
//  Ports       : clk_25   - pixel/byte clock
//                reset_n  - asynchronous active-low reset
//                bus      - dvp_pattern_tx_if.master (enable, pattern_sel in;
//                           data_out, h_ref, v_sync, busy, frame_done out)
//  Options     : DVP_TX_LINE_TAG_EN - when defined, pixel x=0 of every active
//                line carries {6'b0, y[9:0]} instead of the pattern value.
//  Revision    : 1.0 - initial release
// ============================================================================
module dvp_pattern_tx #(
    parameter int H_ACTIVE     = 640,  // active pixels per line, multiple of 8
    parameter int V_ACTIVE     = 480,  // active lines per frame
    parameter int H_BLANK      = 144,  // blank clocks after active bytes
    parameter int BPP          = 2,    // bytes per pixel (RGB565)
    parameter int V_SYNC_LINES = 3,    // lines with v_sync high
    parameter int V_BACK       = 17,   // blank lines after v_sync
    parameter int V_FRONT      = 10    // blank lines after the last active line
) (
    input  wire logic          clk_25,
    input  wire logic          reset_n,
    dvp_pattern_tx_if.master   bus
);

    localparam logic [10:0] c_LINE_LAST   = 11'(H_ACTIVE * BPP + H_BLANK - 1);
    localparam logic [10:0] c_ACT_BYTES   = 11'(H_ACTIVE * BPP);
    localparam logic [9:0]  c_VSYNC_LAST  = 10'(V_SYNC_LINES - 1);
    localparam logic [9:0]  c_VBACK_LAST  = 10'(V_BACK - 1);
    localparam logic [9:0]  c_ACTIVE_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  c_VFRONT_LAST = 10'(V_FRONT - 1);
    localparam logic [9:0]  c_BAR_W       = 10'(H_ACTIVE / 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t      r_state;
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;       // line index within the current state
    logic [1:0]  r_sel;         // pattern latched at VSYNC entry
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_data;
    logic        r_h_ref;
    logic        r_v_sync;
    logic        r_busy;
    logic        r_frame_done;

    state_t      w_state_nxt;
    logic [10:0] w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic [1:0]  w_sel_nxt;
    logic        w_line_end;
    logic        w_last_line;

    logic [9:0]  w_x;
    logic [2:0]  w_bar;
    logic [15:0] w_pix;
    logic        w_h_ref_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_frame_done_nxt;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_sel_nxt   = r_sel;
        w_line_end  = (r_h_cnt == c_LINE_LAST);
        w_last_line = 1'b0;

        case (r_state)
            S_VSYNC:  w_last_line = (r_v_cnt == c_VSYNC_LAST);
            S_VBACK:  w_last_line = (r_v_cnt == c_VBACK_LAST);
            S_ACTIVE: w_last_line = (r_v_cnt == c_ACTIVE_LAST);
            S_VFRONT: w_last_line = (r_v_cnt == c_VFRONT_LAST);
            default:  w_last_line = 1'b0;
        endcase

        if (r_state == S_IDLE) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
            if (bus.enable) begin
                w_state_nxt = S_VSYNC;
                w_sel_nxt   = bus.pattern_sel;
            end
        end else if (!w_line_end) begin
            w_h_nxt = r_h_cnt + 11'd1;
        end else begin
            w_h_nxt = '0;
            if (!w_last_line) begin
                w_v_nxt = r_v_cnt + 10'd1;
            end else begin
                w_v_nxt = '0;
                case (r_state)
                    S_VSYNC:  w_state_nxt = S_VBACK;
                    S_VBACK:  w_state_nxt = S_ACTIVE;
                    S_ACTIVE: w_state_nxt = S_VFRONT;
                    S_VFRONT: begin
                        // Frames always run to completion; enable is only
                        // consulted at the frame boundary.
                        if (bus.enable) begin
                            w_state_nxt = S_VSYNC;
                            w_sel_nxt   = bus.pattern_sel;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default:  w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern generation. Outputs are computed from the next-state view so
    // that the registered outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_x   = w_h_nxt[10:1];
        w_bar = 3'(w_x / c_BAR_W);
        w_pix = 16'h0000;

        case (w_sel_nxt)
            2'd0: w_pix = {{5{w_bar[2]}}, {6{w_bar[1]}}, {5{w_bar[0]}}};
            2'd1: w_pix = {w_x[7:3], w_x[7:2], w_x[7:3]};
            2'd2: w_pix = (w_x[5] ^ w_v_nxt[5]) ? 16'hFFFF : 16'h0000;
            default: w_pix = {r_frame_cnt, r_frame_cnt};
        endcase

`ifdef DVP_TX_LINE_TAG_EN
        if (w_x == 10'd0) begin
            w_pix = {6'b0, w_v_nxt};
        end
`endif

        w_h_ref_nxt      = (w_state_nxt == S_ACTIVE) && (w_h_nxt < c_ACT_BYTES);
        w_data_nxt       = w_h_ref_nxt ? (w_h_nxt[0] ? w_pix[7:0] : w_pix[15:8])
                                       : 8'h00;
        w_frame_done_nxt = (w_state_nxt == S_VFRONT) &&
                           (w_v_nxt == c_VFRONT_LAST) &&
                           (w_h_nxt == c_LINE_LAST);
    end

    // ------------------------------------------------------------------
    // Registered outputs and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= 8'h00;
            r_h_ref      <= 1'b0;
            r_v_sync     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'h00;
        end else begin
            r_data       <= w_data_nxt;
            r_h_ref      <= w_h_ref_nxt;
            r_v_sync     <= (w_state_nxt == S_VSYNC);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_frame_done_nxt;
            // Advances on the edge that ends the frame_done pulse, so a
            // frame always reports the count of frames completed before it.
            if (r_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.h_ref      = r_h_ref;
    assign bus.v_sync     = r_v_sync;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dvp_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dvp_pattern_tx
//  Description : Self-checking bench for dvp_pattern_tx on a reduced frame
//                (8x4 pixels, 4 blank clocks, 1/1/1 sync/back/front lines).
//                Expected line bytes come from a constant vector table and
//                are queued per frame; a monitor pops them on h_ref.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_pattern_tx;

    logic clk_25 = 1'b0;
    logic reset_n;

    always #20 clk_25 = ~clk_25;

    dvp_pattern_tx_if bus_if();

    dvp_pattern_tx #(
        .H_ACTIVE     (8),
        .V_ACTIVE     (4),
        .H_BLANK      (4),
        .BPP          (2),
        .V_SYNC_LINES (1),
        .V_BACK       (1),
        .V_FRONT      (1)
    ) u_dut (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [127:0] line;   // 16 expected bytes of one active line, first byte in MSBs
    } vec_t;

    vec_t        tbl [7];
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          href_lines = 0;
    logic        prev_href = 1'b0;
    logic [127:0] c_bars = 128'h0000_001F_07E0_07FF_F800_F81F_FFE0_FFFF;

    always @(posedge clk_25) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sig(input int id);
        case (id)
            0:       return bus_if.v_sync;
            1:       return bus_if.h_ref;
            2:       return bus_if.frame_done;
            default: return bus_if.busy;
        endcase
    endfunction

    // Waits (on falling edges) for a DUT output to go high, bounded.
    task automatic wait_high(input int id, input int budget, input string name);
        int n = 0;
        while (!sig(id) && n < budget) begin
            @(negedge clk_25);
            n++;
        end
        check(name, {31'd0, sig(id)}, 32'd1);
    endtask

    task automatic push_frame(input logic [127:0] line);
        logic [7:0] b;
        for (int y = 0; y < 4; y++) begin
            for (int i = 0; i < 16; i++) begin
                b = line[127 - 8*i -: 8];
`ifdef DVP_TX_LINE_TAG_EN
                if (i == 0) b = 8'h00;
                if (i == 1) b = 8'(y);
`endif
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_25);
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every h_ref byte must match the queue head, and
    // data must be zero on blank clocks of a frame.
    always @(negedge clk_25) begin
        if (bus_if.h_ref) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra_byte: got 0x%02h, expected no byte (cycle %0d)", bus_if.data_out, cyc);
            end else begin
                exp_b = exp_q.pop_front();
                check("data_byte", {24'd0, bus_if.data_out}, {24'd0, exp_b});
            end
            if (!prev_href) href_lines++;
        end else if (bus_if.busy) begin
            check("data_blank", {24'd0, bus_if.data_out}, 32'd0);
        end
        prev_href = bus_if.h_ref;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish, expected end within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_vs;
        int t_prev;

        tbl[0] = '{2'd3, {16{8'h00}}};
        tbl[1] = '{2'd3, {16{8'h01}}};
        tbl[2] = '{2'd3, {16{8'h02}}};
        tbl[3] = '{2'd0, c_bars};
        tbl[4] = '{2'd1, 128'h0000_0000_0000_0000_0020_0020_0020_0020};
        tbl[5] = '{2'd2, {16{8'h00}}};
        tbl[6] = '{2'd3, {16{8'h06}}};

        reset_n            = 1'b0;
        bus_if.enable      = 1'b0;
        bus_if.pattern_sel = 2'd0;

        // ---- reset state ----
        repeat (3) @(negedge clk_25);
        check("rst_data",   {24'd0, bus_if.data_out}, 32'd0);
        check("rst_href",   {31'd0, bus_if.h_ref},    32'd0);
        check("rst_vsync",  {31'd0, bus_if.v_sync},   32'd0);
        check("rst_busy",   {31'd0, bus_if.busy},     32'd0);
        check("rst_fdone",  {31'd0, bus_if.frame_done}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25);
        check("idle_busy", {31'd0, bus_if.busy}, 32'd0);

        // ---- bars frame: timing, then enable dropped during line 2 ----
        bus_if.pattern_sel = 2'd0;
        bus_if.enable      = 1'b1;
        push_frame(c_bars);
        wait_high(0, 5, "vsync_start");
        t_vs = cyc;
        href_lines = 0;
        check("busy_in_vsync", {31'd0, bus_if.busy}, 32'd1);
        n = 0;
        while (bus_if.v_sync && n < 100) begin
            n++;
            @(negedge clk_25);
        end
        check("vsync_len", n, 20);
        wait_high(1, 60, "href_start");
        check("vsync_to_href", cyc - t_vs, 40);
        n = 0;
        while (bus_if.h_ref && n < 50) begin
            n++;
            @(negedge clk_25);
        end
        check("href_high_len", n, 16);
        n = 0;
        while (!bus_if.h_ref && n < 50) begin
            n++;
            @(negedge clk_25);
        end
        check("href_low_len", n, 4);
        bus_if.enable = 1'b0;       // now inside active line index 1
        wait_high(2, 200, "fdone_after_disable");
        check("lines_in_frame", href_lines, 4);
        @(negedge clk_25);
        check("idle_after_disable", {31'd0, bus_if.busy}, 32'd0);
        n = 0;
        repeat (60) begin
            if (bus_if.v_sync || bus_if.busy) n++;
            @(negedge clk_25);
        end
        check("stays_idle", n, 0);

        // ---- continuous frames from the vector table ----
        do_reset();
        bus_if.pattern_sel = tbl[0].sel;
        bus_if.enable      = 1'b1;
        push_frame(tbl[0].line);
        t_prev = 0;
        for (int i = 1; i < 7; i++) begin
            wait_high(2, 200, "fdone_wait");
            if (i > 1) check("frame_period", cyc - t_prev, 140);
            t_prev = cyc;
            bus_if.pattern_sel = tbl[i].sel;
            push_frame(tbl[i].line);
            @(negedge clk_25);
            check("vsync_after_done", {31'd0, bus_if.v_sync}, 32'd1);
            check("busy_no_gap",      {31'd0, bus_if.busy},   32'd1);
        end
        wait_high(2, 200, "fdone_last");
        check("frame_period", cyc - t_prev, 140);
        bus_if.enable = 1'b0;
        @(negedge clk_25);
        check("end_vsync", {31'd0, bus_if.v_sync}, 32'd0);
        check("end_busy",  {31'd0, bus_if.busy},   32'd0);
        check("table_queue_drained", exp_q.size(), 0);

        // ---- asynchronous reset in the middle of an active line ----
        bus_if.pattern_sel = 2'd0;
        bus_if.enable      = 1'b1;
        push_frame(c_bars);
        wait_high(1, 100, "href_before_reset");
        repeat (5) @(negedge clk_25);
        #5 reset_n = 1'b0;
        #1;
        check("arst_href",  {31'd0, bus_if.h_ref},    32'd0);
        check("arst_vsync", {31'd0, bus_if.v_sync},   32'd0);
        check("arst_data",  {24'd0, bus_if.data_out}, 32'd0);
        check("arst_busy",  {31'd0, bus_if.busy},     32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_25);
        push_frame(c_bars);
        reset_n = 1'b1;
        wait_high(0, 5, "vsync_after_reset");
        n = 0;
        while (bus_if.v_sync && n < 100) begin
            n++;
            @(negedge clk_25);
        end
        check("vsync_len_after_reset", n, 20);
        wait_high(2, 200, "fdone_after_reset");
        bus_if.enable = 1'b0;
        @(negedge clk_25);
        check("idle_after_reset_frame", {31'd0, bus_if.busy}, 32'd0);

        // ---- pattern_sel change mid-frame takes effect next frame ----
        bus_if.pattern_sel = 2'd0;
        bus_if.enable      = 1'b1;
        push_frame(c_bars);
        push_frame({16{8'h00}});
        wait_high(1, 100, "href_before_sel_change");
        bus_if.pattern_sel = 2'd2;
        wait_high(2, 200, "fdone_sel_frame1");
        @(negedge clk_25);
        check("vsync_sel_frame2", {31'd0, bus_if.v_sync}, 32'd1);
        bus_if.enable = 1'b0;
        wait_high(2, 200, "fdone_sel_frame2");
        @(negedge clk_25);
        check("idle_after_sel", {31'd0, bus_if.busy}, 32'd0);

        check("final_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
